// File: rtl/ddr_frame_wr_sched.sv
// ddr_frame_wr_sched: drains the frame packing FIFO into fixed-length Avalon-MM
// write bursts. It also rotates frames across NUM_BUF DDR buffers and publishes the
// writer's next buffer and the last completed buffer for readers.
module ddr_frame_wr_sched #(
    parameter int          BURST_LEN  = 32,
    parameter int          NUM_BUF    = 3,
    parameter logic [31:0] BUF_STRIDE = 32'h0010_0000
) (
    input  logic        clk_100,
    input  logic        reset_n,
    input  logic        start_frame,
    input  logic [31:0] reg_addr_base,
    input  logic [95:0] fifo_rdata,
    input  logic [7:0]  fifo_rdusedw,
    output logic        fifo_rdreq,
    output logic [28:0] avl_address,
    output logic        avl_burstbegin,
    output logic [5:0]  avl_size,
    output logic [7:0]  avl_be,
    output logic [63:0] avl_wdata,
    output logic        avl_write_req,
    input  logic        avl_ready,
    output logic [31:0] frame_addr,
    output logic [31:0] rd_buf_addr,
    output logic        rd_buf_valid,
    output logic        frame_done,
    output logic        frame_late,
    output logic [7:0]  late_cnt
);

    // FIFO head layout
    typedef struct packed {
        logic        last_unit_burst;
        logic        end_write_buf;
        logic        valid;
        logic [28:0] addr;
        logic [63:0] data;
    } fifo_word_t;

    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [7:0] FILL_MIN  = 8'(BURST_LEN);
    localparam logic [5:0] LAST_BEAT = 6'(BURST_LEN - 1);
    localparam logic [1:0] LAST_IDX  = 2'(NUM_BUF - 1);

    fifo_word_t  head;
    state_t      state;
    logic [5:0]  beat_cnt;
    logic [1:0]  wr_idx;
    logic        frame_pending;
    logic        beat_acc;
    logic        eof_beat;
    logic        late_evt;
    logic [31:0] cur_buf_addr;
    logic        unused_flags;

    assign head         = fifo_word_t'(fifo_rdata);
    // Burst flag and word-valid bit are carried through but not acted on.
    assign unused_flags = head.last_unit_burst ^ head.valid;

    assign beat_acc       = avl_write_req & avl_ready;
    assign eof_beat       = beat_acc & head.end_write_buf;
    // A late start is one that finds a frame still draining, unless that
    // frame's last beat retires in the same cycle.
    assign late_evt       = start_frame & frame_pending & ~eof_beat;
    assign fifo_rdreq     = beat_acc;
    assign avl_wdata      = head.data;
    assign avl_burstbegin = avl_write_req & (beat_cnt == 6'd0);
    assign avl_size       = 6'(BURST_LEN);
    assign avl_be         = 8'hFF;
    assign cur_buf_addr   = reg_addr_base + 32'(wr_idx) * BUF_STRIDE;

    // Burst FSM: start once a full burst is buffered, then stream BURST_LEN beats.
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            beat_cnt      <= 6'd0;
            avl_write_req <= 1'b0;
            avl_address   <= 29'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_rdusedw >= FILL_MIN) begin
                        state         <= BURST;
                        avl_write_req <= 1'b1;
                        avl_address   <= head.addr;
                        beat_cnt      <= 6'd0;
                    end
                end
                BURST: begin
                    if (beat_acc) begin
                        beat_cnt <= beat_cnt + 6'd1;
                        if (beat_cnt == LAST_BEAT) begin
                            state         <= IDLE;
                            avl_write_req <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // Buffer rotation: the end-of-frame beat publishes the current buffer and advances.
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            wr_idx       <= 2'd0;
            rd_buf_addr  <= 32'd0;
            rd_buf_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= eof_beat;
            if (eof_beat) begin
                rd_buf_addr  <= cur_buf_addr;
                rd_buf_valid <= 1'b1;
                wr_idx       <= (wr_idx == LAST_IDX) ? 2'd0 : wr_idx + 2'd1;
            end
        end
    end

    // Writer's buffer address, re-registered every cycle from the rotation index.
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) frame_addr <= 32'd0;
        else          frame_addr <= cur_buf_addr;
    end

    // Drain tracking: flag frames that start before the previous one reached DDR.
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            frame_pending <= 1'b0;
            frame_late    <= 1'b0;
            late_cnt      <= 8'd0;
        end else begin
            frame_late <= late_evt;
            if (start_frame)   frame_pending <= 1'b1;
            else if (eof_beat) frame_pending <= 1'b0;
            if (late_evt && late_cnt != 8'hFF) late_cnt <= late_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_ddr_frame_wr_sched.sv
// Bench for ddr_frame_wr_sched: FIFO and DDR port models, a stream-level
// reference (every pushed word is written once, in order), table-driven buffer
// rotation vectors and hand sequences for stalls, latency, late frames and reset.
module tb_ddr_frame_wr_sched;
    localparam int          BL     = 32;
    localparam int          NB     = 3;
    localparam logic [31:0] STRIDE = 32'h0010_0000;

    logic        clk_100 = 1'b0;
    logic        reset_n;
    logic        start_frame;
    logic [31:0] reg_addr_base;
    logic [95:0] fifo_rdata;
    logic [7:0]  fifo_rdusedw;
    logic        fifo_rdreq;
    logic [28:0] avl_address;
    logic        avl_burstbegin;
    logic [5:0]  avl_size;
    logic [7:0]  avl_be;
    logic [63:0] avl_wdata;
    logic        avl_write_req;
    logic        avl_ready;
    logic [31:0] frame_addr;
    logic [31:0] rd_buf_addr;
    logic        rd_buf_valid;
    logic        frame_done;
    logic        frame_late;
    logic [7:0]  late_cnt;

    ddr_frame_wr_sched #(.BURST_LEN(BL), .NUM_BUF(NB), .BUF_STRIDE(STRIDE)) dut (
        .clk_100(clk_100), .reset_n(reset_n), .start_frame(start_frame),
        .reg_addr_base(reg_addr_base), .fifo_rdata(fifo_rdata), .fifo_rdusedw(fifo_rdusedw),
        .fifo_rdreq(fifo_rdreq), .avl_address(avl_address), .avl_burstbegin(avl_burstbegin),
        .avl_size(avl_size), .avl_be(avl_be), .avl_wdata(avl_wdata),
        .avl_write_req(avl_write_req), .avl_ready(avl_ready), .frame_addr(frame_addr),
        .rd_buf_addr(rd_buf_addr), .rd_buf_valid(rd_buf_valid), .frame_done(frame_done),
        .frame_late(frame_late), .late_cnt(late_cnt)
    );

    always #5 clk_100 = ~clk_100;

    typedef struct {
        logic [31:0] base;
        int          nfr;
        logic [31:0] exp_fa;
        logic [31:0] exp_rd;
        logic        exp_vld;
    } row_t;

    logic [95:0] fifo_q[$];
    logic [95:0] exp_q[$];
    int          n_chk = 0, n_err = 0;
    int          bidx, frames, n_req, n_bb, n_acc, n_pop, n_done, n_late;
    int          rdy_mode;
    logic        eof_prev, last_prev, acc, pop_f;
    logic [28:0] burst_addr;
    logic [31:0] base;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_buf(input int idx);
        return base + 32'(idx % NB) * STRIDE;
    endfunction

    function automatic logic [95:0] mkword(input logic [28:0] a, input logic [63:0] d, input logic eof);
        return {1'b0, eof, 1'b1, a, d};
    endfunction

    task automatic fifo_upd();
        fifo_rdata   = (fifo_q.size() > 0) ? fifo_q[0] : 96'h0;
        fifo_rdusedw = (fifo_q.size() > 255) ? 8'd255 : 8'(fifo_q.size());
    endtask

    task automatic push(input logic [95:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_upd();
    endtask

    task automatic push_burst(input logic [28:0] a, input logic eof_last);
        for (int i = 0; i < BL; i++)
            push(mkword(a + 29'(i), {$urandom, $urandom}, eof_last && (i == BL - 1)));
    endtask

    task automatic clr_cnt();
        n_req = 0; n_bb = 0; n_acc = 0; n_pop = 0; n_done = 0; n_late = 0;
    endtask

    // Per-cycle protocol and stream checks, sampled mid-cycle.
    task automatic monitor();
        acc   = avl_write_req & avl_ready;
        pop_f = fifo_rdreq;
        chk("rdreq", 64'(fifo_rdreq), 64'(acc));
        chk("burstbegin", 64'(avl_burstbegin), 64'(avl_write_req && bidx == 0));
        if (last_prev) chk("idle_gap", 64'(avl_write_req), 64'(0));
        chk("frame_done", 64'(frame_done), 64'(eof_prev));
        if (frame_done) begin
            frames++;
            chk("rd_buf_addr", 64'(rd_buf_addr), 64'(exp_buf(frames - 1)));
            chk("rd_buf_valid", 64'(rd_buf_valid), 64'(1));
        end
        if (avl_write_req) begin
            if (exp_q.size() == 0) chk("underflow", 64'(avl_write_req), 64'(0));
            else begin
                if (bidx == 0) burst_addr = exp_q[0][92:64];
                chk("wdata", avl_wdata, exp_q[0][63:0]);
                chk("avl_address", 64'(avl_address), 64'(burst_addr));
            end
        end
        eof_prev  = acc && exp_q.size() > 0 && exp_q[0][94];
        last_prev = acc && bidx == BL - 1;
        if (acc) bidx = (bidx == BL - 1) ? 0 : bidx + 1;
        n_req  += int'(avl_write_req);
        n_bb   += int'(avl_burstbegin);
        n_acc  += int'(acc);
        n_pop  += int'(fifo_rdreq);
        n_done += int'(frame_done);
        n_late += int'(frame_late);
    endtask

    task automatic drive_ready();
        case (rdy_mode)
            1:       avl_ready = ($urandom_range(3) != 0);
            2:       avl_ready = !(avl_write_req && (n_req inside {0, 1, 2, 20, 21, 22}));
            default: avl_ready = 1'b1;
        endcase
    endtask

    task automatic tick();
        @(negedge clk_100);
        monitor();
        @(posedge clk_100);
        #1;
        if (pop_f && fifo_q.size() > 0) fifo_q.delete(0);
        if (acc && exp_q.size() > 0) exp_q.delete(0);
        fifo_upd();
        drive_ready();
        #1;
    endtask

    task automatic tb_rst_state();
        bidx = 0; frames = 0; eof_prev = 1'b0; last_prev = 1'b0;
        acc = 1'b0; pop_f = 1'b0;
    endtask

    task automatic do_reset(input logic clear);
        reset_n     = 1'b0;
        start_frame = 1'b0;
        tb_rst_state();
        if (clear) begin
            fifo_q.delete();
            exp_q.delete();
            fifo_upd();
        end
        tick(); tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_drain(input int bound);
        int k = 0;
        while (exp_q.size() != 0 && k < bound) begin tick(); k++; end
        chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    row_t rows[6];

    initial begin
        rows[0] = '{32'h0000_1000, 0, 32'h0000_1000, 32'h0, 1'b0};
        rows[1] = '{32'h0,         1, 32'h0010_0000, 32'h0, 1'b1};
        rows[2] = '{32'h0,         2, 32'h0020_0000, 32'h0010_0000, 1'b1};
        rows[3] = '{32'h0,         3, 32'h0,         32'h0020_0000, 1'b1};
        rows[4] = '{32'h0000_1000, 4, 32'h0010_1000, 32'h0000_1000, 1'b1};
        rows[5] = '{32'hFFF0_0000, 2, 32'h0010_0000, 32'h0,         1'b1};

        base = 32'h0; reg_addr_base = 32'h0; start_frame = 1'b0; avl_ready = 1'b1;
        rdy_mode = 0; reset_n = 1'b1;
        tb_rst_state(); clr_cnt(); fifo_upd();
        #2;

        // Reset values with a full burst already waiting in the FIFO.
        reset_n = 1'b0;
        #1;
        push_burst(29'h100, 1'b0);
        tick();
        chk("rst_write_req", 64'(avl_write_req), 64'(0));
        chk("rst_rdreq", 64'(fifo_rdreq), 64'(0));
        chk("rst_burstbegin", 64'(avl_burstbegin), 64'(0));
        chk("rst_avl_address", 64'(avl_address), 64'(0));
        chk("rst_frame_addr", 64'(frame_addr), 64'(0));
        chk("rst_rd_buf", 64'({rd_buf_valid, rd_buf_addr}), 64'(0));
        chk("rst_pulses", 64'({frame_done, frame_late, late_cnt}), 64'(0));
        chk("avl_size", 64'(avl_size), 64'(32));
        chk("avl_be", 64'(avl_be), 64'(8'hFF));

        // Basic burst: write_req one cycle after release, 32 back-to-back beats.
        clr_cnt();
        reset_n = 1'b1;
        tick();
        chk("lat_write_req", 64'(avl_write_req), 64'(1));
        chk("first_addr", 64'(avl_address), 64'(29'h100));
        wait_drain(100);
        tick(); tick();
        chk("basic_req_cycles", 64'(n_req), 64'(32));
        chk("basic_bb_cycles", 64'(n_bb), 64'(1));
        chk("basic_pops", 64'(n_pop), 64'(32));
        chk("basic_write_req_off", 64'(avl_write_req), 64'(0));

        // Stalls on beats 0 and 17, three cycles each.
        clr_cnt();
        rdy_mode = 2;
        push_burst(29'h100, 1'b0);
        wait_drain(100);
        tick(); tick();
        rdy_mode = 0;
        chk("stall_bb_cycles", 64'(n_bb), 64'(4));
        chk("stall_req_cycles", 64'(n_req), 64'(38));
        chk("stall_pops", 64'(n_pop), 64'(32));

        // Fill of 31 must not start a burst; the 32nd word starts one a cycle later.
        clr_cnt();
        for (int i = 0; i < BL - 1; i++) push(mkword(29'h300 + 29'(i), {$urandom, $urandom}, 1'b0));
        repeat (8) tick();
        chk("fill31_no_req", 64'(n_req), 64'(0));
        push(mkword(29'h3FF, {$urandom, $urandom}, 1'b0));
        chk("fill32_same_cycle", 64'(avl_write_req), 64'(0));
        tick();
        chk("fill32_next_cycle", 64'(avl_write_req), 64'(1));
        wait_drain(100);
        tick();

        // Table-driven buffer rotation vectors.
        for (int r = 0; r < 6; r++) begin
            do_reset(1'b1);
            base = rows[r].base; reg_addr_base = rows[r].base;
            for (int f = 0; f < rows[r].nfr; f++) begin
                push_burst(29'($urandom), 1'b1);
                wait_drain(200);
            end
            repeat (3) tick();
            chk($sformatf("row%0d_frame_addr", r), 64'(frame_addr), 64'(rows[r].exp_fa));
            chk($sformatf("row%0d_rd_buf_addr", r), 64'(rd_buf_addr), 64'(rows[r].exp_rd));
            chk($sformatf("row%0d_rd_buf_valid", r), 64'(rd_buf_valid), 64'(rows[r].exp_vld));
            chk($sformatf("row%0d_frames", r), 64'(frames), 64'(rows[r].nfr));
        end

        // Late frames, and a start coinciding with the end-of-frame beat.
        do_reset(1'b1);
        base = 32'h0; reg_addr_base = 32'h0;
        clr_cnt();
        start_frame = 1'b1; tick(); start_frame = 1'b0; tick();
        chk("first_start_no_late", 64'({late_cnt, n_late[7:0]}), 64'(0));
        start_frame = 1'b1; tick(); start_frame = 1'b0;
        chk("late_pulse", 64'(frame_late), 64'(1));
        tick();
        chk("late_pulse_width", 64'(frame_late), 64'(0));
        chk("late_cnt_1", 64'(late_cnt), 64'(1));
        chk("late_frame_addr", 64'(frame_addr), 64'(0));
        begin
            logic hit = 1'b0;
            int   k   = 0;
            clr_cnt();
            push_burst(29'h40, 1'b1);
            while (exp_q.size() != 0 && k < 100) begin
                start_frame = avl_write_req && avl_ready && fifo_q.size() > 0 && fifo_q[0][94];
                if (start_frame) hit = 1'b1;
                tick(); k++;
            end
            start_frame = 1'b0;
            repeat (3) tick();
            chk("coinc_hit", 64'(hit), 64'(1));
            chk("coinc_no_late", 64'(n_late), 64'(0));
            chk("coinc_done", 64'(n_done), 64'(1));
            chk("coinc_late_cnt", 64'(late_cnt), 64'(1));
            chk("coinc_frame_addr", 64'(frame_addr), 64'(32'h0010_0000));
        end
        start_frame = 1'b1; tick(); start_frame = 1'b0;
        chk("pending_kept_late", 64'(frame_late), 64'(1));
        tick();
        chk("late_cnt_2", 64'(late_cnt), 64'(2));
        start_frame = 1'b1;
        repeat (300) tick();
        start_frame = 1'b0;
        tick();
        chk("late_cnt_sat", 64'(late_cnt), 64'(255));

        // Reset in the middle of a burst.
        do_reset(1'b1);
        clr_cnt();
        push_burst(29'h500, 1'b0);
        begin
            int k = 0;
            while (n_acc < 10 && k < 100) begin tick(); k++; end
            chk("mid_reach_beat10", 64'(n_acc), 64'(10));
        end
        reset_n = 1'b0;
        tb_rst_state();
        #1;
        chk("mid_write_req", 64'(avl_write_req), 64'(0));
        chk("mid_rdreq", 64'(fifo_rdreq), 64'(0));
        chk("mid_burstbegin", 64'(avl_burstbegin), 64'(0));
        tick(); tick();
        reset_n = 1'b1;
        clr_cnt();
        repeat (10) tick();
        chk("mid_no_restart_at22", 64'(n_req), 64'(0));
        for (int i = 0; i < 10; i++) push(mkword(29'h600 + 29'(i), {$urandom, $urandom}, 1'b0));
        wait_drain(100);
        tick();
        chk("mid_new_burst_beats", 64'(n_acc), 64'(32));
        chk("mid_new_burst_bb", 64'(n_bb), 64'(1));

        // Randomized traffic against the stream-level reference.
        begin
            int pushed = 0, n_eof = 0, k = 0;
            do_reset(1'b1);
            base = $urandom; reg_addr_base = base;
            clr_cnt();
            rdy_mode = 1;
            while (!(pushed == 256 && exp_q.size() == 0) && k < 6000) begin
                if (pushed < 256 && fifo_q.size() < 200 && $urandom_range(1) == 1) begin
                    logic eof = ($urandom_range(19) == 0);
                    logic [95:0] w = {1'($urandom), eof, 1'($urandom), 29'($urandom), $urandom, $urandom};
                    push(w);
                    pushed++;
                    n_eof += int'(eof);
                end
                tick(); k++;
            end
            rdy_mode = 0;
            repeat (3) tick();
            chk("rand_all_written", 64'(n_acc), 64'(256));
            chk("rand_pops", 64'(n_pop), 64'(256));
            chk("rand_frames", 64'(frames), 64'(n_eof));
            chk("rand_frame_addr", 64'(frame_addr), 64'(exp_buf(n_eof)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
